// File: rtl/miner_serial_pkg.sv
// ---------------------------------------------------------------------------
// miner_serial_pkg
//
// Shared constants and types for the miner board serial link: the 44-byte
// work frame (256-bit midstate followed by 96-bit data2) that travels
// between boards, and the state encoding of the work forwarding FSM.
// The frame geometry is owned by the receiver (serial_receive), so every
// block on the link takes its widths from here.
// ---------------------------------------------------------------------------
package miner_serial_pkg;

    // Frame geometry shared by serial_receive and work_forward_tx
    localparam int BYTE_BITS     = 8;
    localparam int WORK_BYTES    = 44;
    localparam int MIDSTATE_BITS = 256;
    localparam int DATA2_BITS    = 96;
    localparam int WORK_BITS     = MIDSTATE_BITS + DATA2_BITS;

    // Byte index within a frame; 44..63 are never reached
    localparam int BYTE_CNT_BITS = 6;

    // Width of the completed-frame counter
    localparam int FRAME_CNT_BITS = 16;

    // Work forwarding FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2,
        ST_DRAIN = 2'd3
    } fwd_state_t;

    // The link is MSB-first: the next byte on the wire is always the top
    // byte of the work word, because the receiver shifts left.
    function automatic logic [BYTE_BITS-1:0] top_byte(input logic [WORK_BITS-1:0] w);
        return w[WORK_BITS-1 -: BYTE_BITS];
    endfunction

endpackage

// File: rtl/work_forward_tx_if.sv
// ---------------------------------------------------------------------------
// work_forward_tx_if
//
// Byte-level handshake between the work forwarder and a serial_tx UART
// transmitter.
//   tx_data      8  byte to transmit, valid while tx_new_data is high
//   tx_new_data  1  one-cycle start pulse for the transmitter
//   tx_busy      1  transmitter busy; rises the cycle after tx_new_data and
//                   falls when the stop bit completes
// Modports:
//   master  - the byte producer (work_forward_tx)
//   slave   - the transmitter (serial_tx)
// ---------------------------------------------------------------------------
interface work_forward_tx_if;
    import miner_serial_pkg::*;

    logic [BYTE_BITS-1:0] tx_data;
    logic                 tx_new_data;
    logic                 tx_busy;

    modport master (
        output tx_data,
        output tx_new_data,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_new_data,
        output tx_busy
    );

endinterface

// File: rtl/work_forward_tx_toggle_detect.sv
// ---------------------------------------------------------------------------
// toggle_detect
//
// Turns a toggle-style event flag into a one-cycle change strobe. The flag
// must already be synchronous to clk. Two toggles between samples cancel
// and are not seen; producers on the miner link toggle at most once per
// frame, so that cannot happen in practice.
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   flag_in  in  toggle-style event flag
//   change   out high for the cycle in which flag_in differs from its
//                previous value
// ---------------------------------------------------------------------------
module toggle_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic flag_in,
    output logic change
);

    logic flag_q;

    // Remember last cycle's flag so any edge on it shows up as a difference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_in;
        end
    end

    assign change = flag_in ^ flag_q;

endmodule

// File: rtl/work_forward_tx.sv
// ---------------------------------------------------------------------------
// work_forward_tx
//
// Forwards one mining work unit (midstate + data2) to the next board as a
// 44-byte MSB-first frame over a byte-level UART transmitter. Every
// load_flag toggle produces one frame; work arriving while a frame is in
// flight is held in a one-deep pending buffer where newer work replaces
// older work, so the most recent work is always the next one sent.
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   midstate     in   256-bit work midstate, sampled on a load_flag toggle
//   data2        in   96-bit work tail, sampled with midstate
//   load_flag    in   toggle-style "new work" flag, synchronous to clk
//   tx           --   master side of the serial_tx byte handshake
//   busy         out  a frame is being sent or is waiting to be sent
//   frames_sent  out  completed frame count, wraps at 2^16
// ---------------------------------------------------------------------------
module work_forward_tx
    import miner_serial_pkg::*;
#(
    // Frame length is fixed by the receiver; leave at the default
    parameter int WORK_BYTES = miner_serial_pkg::WORK_BYTES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [MIDSTATE_BITS-1:0]  midstate,
    input  logic [DATA2_BITS-1:0]     data2,
    input  logic                      load_flag,
    work_forward_tx_if.master         tx,
    output logic                      busy,
    output logic [FRAME_CNT_BITS-1:0] frames_sent
);

    localparam logic [BYTE_CNT_BITS-1:0] LAST_BYTE = BYTE_CNT_BITS'(WORK_BYTES - 1);

    logic                      change;
    fwd_state_t                state;
    fwd_state_t                state_next;
    logic [WORK_BITS-1:0]      pend_buf;
    logic                      pending;
    logic [WORK_BITS-1:0]      shift_buf;
    logic [BYTE_CNT_BITS-1:0]  byte_cnt;
    logic [BYTE_BITS-1:0]      tx_data_q;
    logic [FRAME_CNT_BITS-1:0] frames_cnt;
    logic                      start_frame;
    logic                      issue_byte;
    logic                      next_byte;
    logic                      frame_done;

    toggle_detect u_toggle_detect (
        .clk     (clk),
        .rst_n   (rst_n),
        .flag_in (load_flag),
        .change  (change)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle actions. GUARD deliberately ignores
    // tx_busy: the transmitter only raises busy the cycle after the start
    // pulse, so looking at it one cycle too early would see the stale low
    // and start the next byte on top of the current one.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        issue_byte  = 1'b0;
        next_byte   = 1'b0;
        frame_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    start_frame = 1'b1;
                    state_next  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx.tx_busy) begin
                    issue_byte = 1'b1;
                    state_next = ST_GUARD;
                end
            end
            ST_GUARD: begin
                state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!tx.tx_busy) begin
                    if (byte_cnt == LAST_BYTE) begin
                        frame_done = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        next_byte  = 1'b1;
                        state_next = ST_SEND;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pending work buffer. A toggle always wins over the clear that happens
    // when a frame starts, so work landing in the IDLE->SEND cycle is kept
    // and sent as a following frame. A toggle while pending just replaces
    // the older unsent work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_buf <= '0;
            pending  <= 1'b0;
        end else if (change) begin
            pend_buf <= {midstate, data2};
            pending  <= 1'b1;
        end else if (start_frame) begin
            pending  <= 1'b0;
        end
    end

    // Frame datapath. The frame in flight runs from its own copy in
    // shift_buf, so new work arriving mid-frame cannot corrupt it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_buf  <= '0;
            byte_cnt   <= '0;
            tx_data_q  <= '0;
            frames_cnt <= '0;
        end else begin
            if (start_frame) begin
                shift_buf <= pend_buf;
                byte_cnt  <= '0;
            end else if (issue_byte) begin
                shift_buf <= shift_buf << BYTE_BITS;
                tx_data_q <= top_byte(shift_buf);
            end else if (next_byte) begin
                byte_cnt  <= byte_cnt + 1'b1;
            end
            if (frame_done) begin
                frames_cnt <= frames_cnt + 1'b1;
            end
        end
    end

    // tx_data shows the byte about to go out while in SEND and otherwise
    // keeps the last byte issued, so the transmitter sees stable data.
    assign tx.tx_data     = (state == ST_SEND) ? top_byte(shift_buf) : tx_data_q;
    assign tx.tx_new_data = issue_byte;
    assign busy           = (state != ST_IDLE) | pending;
    assign frames_sent    = frames_cnt;

endmodule

// File: doc/work_forward_tx.md
# work_forward_tx

Serializes one mining work unit onto a byte-level UART transmitter: a 256-bit midstate and a 96-bit data2 word, sent as 44 bytes. It is the sending end of the 44-byte work frame accepted by `serial_receive`. It sits in the master board of a daisy-chained miner cluster, between the local `serial_receive` outputs (`midstate`, `data2`, `load_flag`) and a `serial_tx` instance that drives the link to the next board. New work is signalled by a toggle, and each toggle produces exactly one frame. If work arrives while a frame is in flight, the newest work is sent next.

## Interface
- `WORK_BYTES`, default 44: frame length in bytes. It is fixed by the receiver and must not be overridden.
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `midstate`  in  256  work midstate. Sampled only when a `load_flag` toggle is detected.
- `data2`  in  96  work tail. Sampled together with `midstate`.
- `load_flag`  in  1  toggle-style "new work" indication. It is synchronous to `clk`.
- `tx_data`  out  8  byte presented to `serial_tx`.
- `tx_new_data`  out  1  one-cycle start pulse to `serial_tx`.
- `tx_busy`  in  1  `serial_tx` busy. It rises the cycle after `tx_new_data` and falls when the stop bit completes.
- `busy`  out  1  high while a frame is being sent or is pending.
- `frames_sent`  out  16  count of completed frames. Wraps from 0xFFFF to 0.

## Operation
- **Toggle detect:** register `flag_q` holds the previous `load_flag`.
  - `flag_q` resets to 0.
  - `change = load_flag ^ flag_q`.
  - Two toggles between samples cancel each other and are not seen. This is acceptable, because the receiver toggles at most once per 44 bytes.
- **Capture:** on `change`, latch `{midstate, data2}` (352 bits) into `pend_buf` and set `pending`.
  - If `pending` is already set, the buffer is overwritten: newest wins.
- **Byte order:** byte 0 is `pend[351:344]` (`midstate[255:248]`), and so on down to byte 43, which is `data2[7:0]`. MSB-first is required because the receiver shifts left.
- **FSM states:**
  - **IDLE:** if `pending`, copy `pend_buf` into `shift_buf`, clear `pending` (unless `change` is active in the same cycle), set `byte_cnt` to 0, and go to SEND.
  - **SEND:** if `!tx_busy`:
    - drive `tx_data = shift_buf[351:344]` and pulse `tx_new_data`;
    - shift `shift_buf` left by 8;
    - go to GUARD.
  - **GUARD:** one cycle, ignoring `tx_busy`. This covers the busy-rise latency. Go to DRAIN.
  - **DRAIN:** wait for `!tx_busy`. Then:
    - if `byte_cnt == 43`, increment `frames_sent` and go to IDLE;
    - otherwise increment `byte_cnt` and go to SEND.
- `tx_data` holds its last value outside SEND. `tx_new_data` is high only in the SEND cycle that issues a byte.
- `busy = (state != IDLE) | pending`.
- **Width rules:**
  - `byte_cnt` is 6 bits; values 44–63 are unreachable.
  - `frames_sent` is a modulo-2^16 increment.

## Timing
- **Reset values:** `tx_data` = 0x00, `tx_new_data` = 0, `busy` = 0, `frames_sent` = 0; state is IDLE; `pending` = 0; `flag_q` = 0.
- **Latency:** from a `load_flag` toggle at cycle N (with `tx_busy` low), the first `tx_new_data` occurs at cycle N+2:
  - capture at N;
  - IDLE→SEND at N+1;
  - pulse at N+2.
- **Per byte:** pulse, guard, then drain until `tx_busy` falls, then the next SEND. This gives 2 cycles plus the `serial_tx` byte time.
- **Toggle during a frame:** the current frame completes unmodified (it uses `shift_buf`), and the pending work starts from IDLE one cycle after the last byte's drain.
- **Toggle in the IDLE→SEND cycle:** the new data goes to `pend_buf`, `pending` stays set, and a second frame follows.
- **`tx_busy` already high when entering SEND:** wait without pulsing.
- **Reset mid-frame:** outputs return to reset values immediately and the partial frame is abandoned. The downstream receiver recovers through its 2^23-cycle idle timeout. No resend is performed.

## Structure
- The shared package `miner_serial_pkg` holds:
  - `WORK_BYTES = 44`;
  - `WORK_BITS = 352`;
  - `MIDSTATE_BITS = 256`;
  - `DATA2_BITS = 96`;
  - the FSM state encoding (IDLE, SEND, GUARD, DRAIN).
- `serial_receive`'s width constants move there as well.
- One sub-module is natural: `toggle_detect`, containing the `flag_q` register and the XOR. It is reusable for the receiver's `load_flag` consumers.
- `serial_tx` is instantiated by the parent, not inside this block.

## Test plan
- **Single frame:** after reset, with `midstate = 0x00010203…1F` (bytes 0..31) and `data2 = 0x2021…2B`, toggle `load_flag` once. Expect exactly 44 pulses carrying 0x00..0x2B in order, then `frames_sent` = 1 and `busy` = 0.
- **Overwrite:** toggle with work A, then toggle B and C during byte 10 of A. Expect A to complete, then exactly one frame C; B is never sent; `frames_sent` = 2.
- **Handshake:** a `tx_busy` model that holds busy for 100 cycles, plus a `tx_busy` forced high for 50 cycles before SEND. Expect no `tx_new_data` while busy, and pulses exactly 2 cycles after each busy fall.
- **Reset mid-frame:** assert `rst_n` low at byte 20. Expect all outputs at reset values the same cycle, and no further pulses after release until a new toggle.
- **Loopback:** feed `tx_data`/`tx_new_data` through `serial_tx` into `serial_receive`. Expect the receiver's `midstate`/`data2` to equal the sent work and its `load_flag` to toggle once per frame.
- **Counter wrap:** preload 0xFFFF frames by force, send one frame. Expect `frames_sent` = 0x0000.
